// File: rtl/fir_serial_mac_filter.sv
// Serial FIR filter: one shared multiply-accumulate walks a circular sample buffer per input sample,
// then the accumulator is rounded half-up, saturated to the sample width and presented with a one-cycle pulse.
module fir_serial_mac_filter #(
    parameter  int NTAPS = 65,
    parameter  int DW    = 16,
    parameter  int CW    = 16,
    parameter  int ACCW  = 40,
    parameter  int SHIFT = 15,
    localparam int AW    = $clog2(NTAPS)
) (
    input  logic          sample_clock,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_sample,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic          out_valid,
    output logic [DW-1:0] out_sample,
    output logic          sat_flag,
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

    localparam logic [AW:0]            NTAPS_W = (AW+1)'(NTAPS);
    localparam logic [AW-1:0]          LAST_K  = AW'(NTAPS - 1);
    localparam logic signed [ACCW-1:0] RND_C   = {{(ACCW-1){1'b0}}, 1'b1} <<< (SHIFT - 1);
    localparam logic signed [ACCW-1:0] MAX_C   = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MIN_C   = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DW-1:0]           r_buf  [NTAPS];
    logic [CW-1:0]           r_coef [NTAPS];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_k;
    logic signed [ACCW-1:0]  r_acc;
    logic [DW-1:0]           r_res;
    logic                    r_clip;

    logic                    w_accept;
    logic                    w_coef_wr;
    logic [AW:0]             w_diff;
    logic [AW:0]             w_idx;
    logic signed [DW+CW-1:0] w_prod;
    logic signed [ACCW-1:0]  w_prod_ext;
    logic signed [ACCW-1:0]  w_rnd;
    logic signed [ACCW-1:0]  w_shr;
    logic [DW-1:0]           w_clip_val;
    logic                    w_clip;

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_coef_wr = coef_we && (r_state == S_IDLE) && ({1'b0, coef_addr} < NTAPS_W);

    // Next-state decode for the accept/MAC/round/output sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next_state = S_MAC; else w_next_state = S_IDLE;
            S_MAC:   if (r_k == LAST_K) w_next_state = S_ROUND; else w_next_state = S_MAC;
            S_ROUND: w_next_state = S_OUT;
            S_OUT:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Tap k reads the sample k positions older than the newest, modulo the buffer length.
    always_comb begin
        w_diff = {1'b0, r_wr_ptr} - {1'b0, r_k};
        w_idx  = w_diff;
        if (r_k > r_wr_ptr) begin
            w_idx = w_diff + NTAPS_W;
        end else begin
            w_idx = w_diff;
        end
    end

    assign w_prod     = $signed(r_coef[r_k]) * $signed(r_buf[w_idx[AW-1:0]]);
    assign w_prod_ext = {{(ACCW-DW-CW){w_prod[DW+CW-1]}}, w_prod};
    assign w_rnd      = r_acc + RND_C;
    assign w_shr      = w_rnd >>> SHIFT;

    // Saturate the rounded result to the signed output range.
    always_comb begin
        w_clip_val = w_shr[DW-1:0];
        w_clip     = 1'b0;
        if (w_shr > MAX_C) begin
            w_clip_val = {1'b0, {(DW-1){1'b1}}};
            w_clip     = 1'b1;
        end else if (w_shr < MIN_C) begin
            w_clip_val = {1'b1, {(DW-1){1'b0}}};
            w_clip     = 1'b1;
        end else begin
            w_clip_val = w_shr[DW-1:0];
            w_clip     = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge sample_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Sample and coefficient storage.
    always_ff @(posedge sample_clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_buf[i]  <= '0;
                r_coef[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_buf[r_wr_ptr] <= in_sample;
            end
            if (w_coef_wr) begin
                r_coef[coef_addr] <= coef_data;
            end
        end
    end

    // MAC datapath, rounding stage and write pointer.
    always_ff @(posedge sample_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_res    <= '0;
            r_clip   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc <= '0;
                        r_k   <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_k != LAST_K) begin
                        r_k <= r_k + AW'(1);
                    end
                end
                S_ROUND: begin
                    r_res  <= w_clip_val;
                    r_clip <= w_clip;
                end
                S_OUT: begin
                    if (r_wr_ptr == LAST_K) begin
                        r_wr_ptr <= '0;
                    end else begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                    end
                end
                default: begin
                    r_k <= '0;
                end
            endcase
        end
    end

    // Registered output pulse; sample and flag hold between pulses.
    always_ff @(posedge sample_clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
            sat_flag   <= 1'b0;
        end else if (r_state == S_OUT) begin
            out_valid  <= 1'b1;
            out_sample <= r_res;
            sat_flag   <= r_clip;
        end else begin
            out_valid  <= 1'b0;
        end
    end

endmodule
